elevator_scan_ctrl: RTL

//  Parametrised single-car elevator controller for NUM_FLOORS floors. Hall calls and car

---
 rtl/elevator_pkg.sv | 62 ++++++
 rtl/elevator_req_latch.sv | 37 +++
 rtl/elevator_scan_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types, motor encodings and SCAN helpers for the elevator controller.
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN,
        ST_DOOR_CLOSE,
        ST_FIRE_RECALL,
        ST_HOLD
    } state_t;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b01;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    // Helpers work on a fixed-width vector; callers zero-extend their pending bits.
    localparam int MAX_FLOORS = 64;

    typedef struct packed {
        state_t next_state;
        logic   dir_up;
    } scan_dec_t;

    function automatic logic req_above(input logic [MAX_FLOORS-1:0] req,
                                       input int unsigned floor);
        logic [MAX_FLOORS-1:0] shifted;
        shifted = (req >> floor) >> 1;
        return |shifted;
    endfunction

    function automatic logic req_below(input logic [MAX_FLOORS-1:0] req,
                                       input int unsigned floor);
        logic [MAX_FLOORS-1:0] below_mask;
        below_mask = (MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1);
        return |(req & below_mask);
    endfunction

    // SCAN choice made whenever the car is parked with the door shut.
    function automatic scan_dec_t scan_decide(input logic here, input logic dir_up,
                                              input logic above, input logic below);
        scan_dec_t d;
        d.next_state = ST_IDLE;
        d.dir_up     = dir_up;
        if (here) begin
            d.next_state = ST_DOOR_OPEN;
        end else if (dir_up && above) begin
            d.next_state = ST_MOVE_UP;
        end else if (!dir_up && below) begin
            d.next_state = ST_MOVE_DOWN;
        end else if (dir_up && below) begin
            d.next_state = ST_MOVE_DOWN;
            d.dir_up     = 1'b0;
        end else if (!dir_up && above) begin
            d.next_state = ST_MOVE_UP;
            d.dir_up     = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Pending-request register: sticky OR of incoming calls, masked clear (clear wins).
module elevator_req_latch
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req_set,
    input  logic [NUM_FLOORS-1:0] req_clr,
    input  logic                  en,
    input  logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below
);

    logic [MAX_FLOORS-1:0] pend_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | (en ? req_set : '0)) & ~req_clr;
        end
    end

    always_comb begin
        pend_ext                 = '0;
        pend_ext[NUM_FLOORS-1:0] = pending;
    end

    assign any_above = req_above(pend_ext, 32'(floor));
    assign any_below = req_below(pend_ext, 32'(floor));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller with fire recall and power-fail hold.
// Optional DOOR_HOLD_EN adds a door_hold input that extends the door dwell.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int MOVE_TICKS = 8,
    parameter int DOOR_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic                  fire_alarm,
    input  logic                  power_outage,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [1:0]            motor,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    floor_display,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  emergency
);

    localparam int MOVE_W = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int DOOR_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [MOVE_W-1:0] MOVE_LOAD = MOVE_W'(MOVE_TICKS - 1);
    localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_TICKS - 1);

    state_t               state, state_nx;
    logic [FLOOR_W-1:0]   floor_q, floor_nx, floor_up, floor_dn;
    logic                 dir_q, dir_nx;
    logic [MOVE_W-1:0]    move_cnt, move_nx;
    logic [DOOR_W-1:0]    door_cnt, door_nx;
    logic [NUM_FLOORS-1:0] req_clr;
    logic                 latch_en, any_above, any_below, hold_req;
    scan_dec_t            dec;

`ifdef DOOR_HOLD_EN
    assign hold_req = door_hold;
`else
    assign hold_req = 1'b0;
`endif

    assign floor_up = floor_q + FLOOR_W'(1);
    assign floor_dn = floor_q - FLOOR_W'(1);
    assign latch_en = (state != ST_FIRE_RECALL) && (state != ST_HOLD);

    elevator_req_latch #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_latch (
        .clk       (clk),
        .reset     (reset),
        .req_set   (call_up | call_down | car_req),
        .req_clr   (req_clr),
        .en        (latch_en),
        .floor     (floor_q),
        .pending   (pending),
        .any_above (any_above),
        .any_below (any_below)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            move_cnt <= '0;
            door_cnt <= '0;
        end else begin
            state    <= state_nx;
            floor_q  <= floor_nx;
            dir_q    <= dir_nx;
            move_cnt <= move_nx;
            door_cnt <= door_nx;
        end
    end

    always_comb begin
        state_nx = state;
        floor_nx = floor_q;
        dir_nx   = dir_q;
        move_nx  = move_cnt;
        door_nx  = door_cnt;
        dec      = scan_decide(pending[floor_q], dir_q, any_above, any_below);

        case (state)
            ST_IDLE, ST_DOOR_CLOSE: begin
                if (state == ST_DOOR_CLOSE && hold_req) begin
                    state_nx = ST_DOOR_OPEN;
                    door_nx  = DOOR_LOAD;
                end else begin
                    state_nx = dec.next_state;
                    dir_nx   = dec.dir_up;
                    if (dec.next_state == ST_DOOR_OPEN) begin
                        door_nx = DOOR_LOAD;
                    end
                    // A nonzero count means a move interrupted by HOLD; resume it.
                    if ((dec.next_state == ST_MOVE_UP || dec.next_state == ST_MOVE_DOWN)
                        && move_cnt == '0) begin
                        move_nx = MOVE_LOAD;
                    end
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (move_cnt == '0) begin
                    floor_nx = (state == ST_MOVE_UP) ? floor_up : floor_dn;
                    if (pending[floor_nx]) begin
                        state_nx = ST_DOOR_OPEN;
                        move_nx  = '0;
                        door_nx  = DOOR_LOAD;
                    end else begin
                        move_nx = MOVE_LOAD;
                    end
                end else begin
                    move_nx = move_cnt - MOVE_W'(1);
                end
            end
            ST_DOOR_OPEN: begin
                if (hold_req) begin
                    door_nx = DOOR_LOAD;
                end else if (door_cnt == '0) begin
                    state_nx = ST_DOOR_CLOSE;
                end else begin
                    door_nx = door_cnt - DOOR_W'(1);
                end
            end
            ST_FIRE_RECALL: begin
                if (floor_q == '0) begin
                    move_nx = '0;
                end else if (move_cnt == '0) begin
                    floor_nx = floor_dn;
                    move_nx  = (floor_dn == '0) ? '0 : MOVE_LOAD;
                end else begin
                    move_nx = move_cnt - MOVE_W'(1);
                end
            end
            default: ;
        endcase

        // Emergency inputs override whatever the normal sequencing chose.
        if (power_outage) begin
            state_nx = ST_HOLD;
            floor_nx = floor_q;
            dir_nx   = dir_q;
            move_nx  = move_cnt;
            door_nx  = door_cnt;
        end else if (fire_alarm) begin
            if (state != ST_FIRE_RECALL) begin
                state_nx = ST_FIRE_RECALL;
                floor_nx = floor_q;
                dir_nx   = dir_q;
                door_nx  = door_cnt;
                if (floor_q == '0) begin
                    move_nx = '0;
                end else if (move_cnt == '0) begin
                    move_nx = MOVE_LOAD;
                end else begin
                    move_nx = move_cnt;
                end
            end
        end else if (state == ST_FIRE_RECALL || state == ST_HOLD) begin
            state_nx = ST_IDLE;
            dir_nx   = 1'b1;
        end
    end

    always_comb begin
        req_clr = '0;
        if (state_nx == ST_FIRE_RECALL) begin
            req_clr = '1;
        end else begin
            if (state_nx == ST_DOOR_OPEN) begin
                req_clr = req_clr | (NUM_FLOORS'(1) << floor_nx);
            end
            if (state == ST_DOOR_OPEN) begin
                req_clr = req_clr | (NUM_FLOORS'(1) << floor_q);
            end
        end
    end

    always_comb begin
        motor     = MOTOR_STOP;
        door_open = 1'b0;
        emergency = 1'b0;
        case (state)
            ST_MOVE_UP:   motor = MOTOR_UP;
            ST_MOVE_DOWN: motor = MOTOR_DOWN;
            ST_DOOR_OPEN: door_open = 1'b1;
            ST_FIRE_RECALL: begin
                emergency = 1'b1;
                if (floor_q == '0) begin
                    door_open = 1'b1;
                end else begin
                    motor = MOTOR_DOWN;
                end
            end
            ST_HOLD: begin
                emergency = 1'b1;
                door_open = (move_cnt == '0);
            end
            default: ;
        endcase
    end

    assign floor_display = floor_q;
    assign dir_up        = dir_q;

endmodule
